// File: rtl/sha_block_sequencer_pkg.sv
// Shared types and codes for the SHA nonce-search block sequencer.
package sha_block_sequencer_pkg;

  localparam int DEFAULT_ROUNDS = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_ACCUM,
    S_CHECK
  } seq_state_t;

  // Phase codes presented to the H0..H7 accumulators
  localparam logic [1:0] BLK_INIT   = 2'd0;
  localparam logic [1:0] BLK_CHUNK1 = 2'd1;
  localparam logic [1:0] BLK_CHUNK2 = 2'd2;
  localparam logic [1:0] BLK_FINAL  = 2'd3;

  // Message sources for the W schedule
  localparam logic [1:0] SEL_HDR1   = 2'd0;
  localparam logic [1:0] SEL_HDR2   = 2'd1;
  localparam logic [1:0] SEL_DIGEST = 2'd2;

  function automatic logic [1:0] blk_after(input logic [1:0] sel);
    case (sel)
      SEL_HDR1: blk_after = BLK_CHUNK1;
      SEL_HDR2: blk_after = BLK_CHUNK2;
      default:  blk_after = BLK_FINAL;
    endcase
  endfunction

endpackage

// File: rtl/sha_block_sequencer_round_counter.sv
// Loadable round counter: clears to 0, counts while enabled, wraps to 0 after
// the terminal round so it is ready for the next chunk.
module sha_round_counter import sha_block_sequencer_pkg::*; #(
  parameter int ROUNDS = DEFAULT_ROUNDS,
  parameter int CW     = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  assign tc = (count == CW'(ROUNDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/sha_block_sequencer.sv
// Sequences the three SHA-256 chunk passes of a double-hash nonce search.
// Optional feature: define SHA_SEQ_MIDSTATE_EN to reuse the chunk1 midstate after a miss.
module sha_block_sequencer import sha_block_sequencer_pkg::*; #(
  parameter int ROUNDS = DEFAULT_ROUNDS,
  parameter int CW     = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   nonce_base,
  input  logic          hash_hit,
  output logic [1:0]    block,
  output logic [1:0]    chunk_sel,
  output logic          w_load,
  output logic          round_en,
  output logic [CW-1:0] round,
  output logic          accum_en,
  output logic [31:0]   nonce,
  output logic          busy,
  output logic          done,
  output logic          found
);

  seq_state_t state, state_n;
  logic       round_tc;
  logic       nonce_last;

  assign nonce_last = (nonce == 32'hFFFF_FFFF);
  assign w_load     = (state == S_LOAD);
  assign round_en   = (state == S_ROUND);
  assign accum_en   = (state == S_ACCUM);

  sha_round_counter #(
    .ROUNDS (ROUNDS),
    .CW     (CW)
  ) u_round_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear ((state != S_ROUND) || abort),
    .en    (round_en),
    .count (round),
    .tc    (round_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start && !abort) state_n = S_LOAD;
      S_LOAD:  state_n = S_ROUND;
      S_ROUND: if (round_tc) state_n = S_ACCUM;
      S_ACCUM: state_n = (chunk_sel == SEL_DIGEST) ? S_CHECK : S_LOAD;
      S_CHECK: state_n = (hash_hit || nonce_last) ? S_IDLE : S_LOAD;
      default: state_n = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_n = S_IDLE;
  end

  // Block code changes on entry to ACCUM so the strobe sees the new phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block     <= BLK_INIT;
      chunk_sel <= SEL_HDR1;
      nonce     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        busy      <= 1'b0;
        done      <= 1'b1;
        found     <= 1'b0;
        block     <= BLK_INIT;
        chunk_sel <= SEL_HDR1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              nonce     <= nonce_base;
              busy      <= 1'b1;
              found     <= 1'b0;
              block     <= BLK_INIT;
              chunk_sel <= SEL_HDR1;
            end
          end
          S_ROUND: begin
            if (round_tc) block <= blk_after(chunk_sel);
          end
          S_ACCUM: begin
            if (chunk_sel == SEL_HDR1) chunk_sel <= SEL_HDR2;
            else if (chunk_sel == SEL_HDR2) chunk_sel <= SEL_DIGEST;
          end
          S_CHECK: begin
            if (hash_hit || nonce_last) begin
              done      <= 1'b1;
              found     <= hash_hit;
              busy      <= 1'b0;
              block     <= BLK_INIT;
              chunk_sel <= SEL_HDR1;
            end else begin
              nonce <= nonce + 32'd1;
`ifdef SHA_SEQ_MIDSTATE_EN
              block     <= BLK_CHUNK1;
              chunk_sel <= SEL_HDR2;
`else
              block     <= BLK_INIT;
              chunk_sel <= SEL_HDR1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha_block_sequencer.sv
// Directed self-checking bench for sha_block_sequencer (default ROUNDS=64).
module tb_sha_block_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] nonce_base;
  logic        hash_hit;
  logic [1:0]  block;
  logic [1:0]  chunk_sel;
  logic        w_load;
  logic        round_en;
  logic [5:0]  round;
  logic        accum_en;
  logic [31:0] nonce;
  logic        busy;
  logic        done;
  logic        found;

  localparam int FIRST_COST = 199;
`ifdef SHA_SEQ_MIDSTATE_EN
  localparam int MISS_COST  = 133;
  localparam int FOURTH_BLK = 2;
`else
  localparam int MISS_COST  = 199;
  localparam int FOURTH_BLK = 1;
`endif

  int errors = 0;
  int checks = 0;
  int exclBad = 0;
  int doneCount = 0;
  int cycles;
  int doneBefore;
  logic [1:0]  blkQ[$];
  logic [31:0] nonceQ[$];

  sha_block_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .nonce_base (nonce_base),
    .hash_hit   (hash_hit),
    .block      (block),
    .chunk_sel  (chunk_sel),
    .w_load     (w_load),
    .round_en   (round_en),
    .round      (round),
    .accum_en   (accum_en),
    .nonce      (nonce),
    .busy       (busy),
    .done       (done),
    .found      (found)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ($countones({w_load, round_en, accum_en}) > 1) exclBad++;
    if (done) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] base);
    nonce_base = base;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Counts edges until done, optionally raising hash_hit at a given edge.
  task automatic waitDone(input int hitAt, output int n);
    n = 0;
    blkQ.delete();
    nonceQ.delete();
    while (n < 1000) begin
      tick(1);
      n++;
      if (hitAt != 0 && n == hitAt) hash_hit = 1'b1;
      if (accum_en) begin
        blkQ.push_back(block);
        if (block == 2'd3) nonceQ.push_back(nonce);
      end
      if (done) break;
    end
    hash_hit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; nonce_base = '0; hash_hit = 1'b0;
    #2;
    checkOutput("rst_block", 32'(block), 0);
    checkOutput("rst_chunk_sel", 32'(chunk_sel), 0);
    checkOutput("rst_round", 32'(round), 0);
    checkOutput("rst_nonce", nonce, 0);
    checkOutput("rst_flags", {26'd0, w_load, round_en, accum_en, busy, done, found}, 0);
    #10 rst_n = 1'b1;
    tick(2);

    $display("[TB] single nonce hit");
    hash_hit = 1'b1;
    applyStimulus(32'd5);
    waitDone(0, cycles);
    checkOutput("hit_latency", cycles, FIRST_COST);
    checkOutput("hit_found", 32'(found), 1);
    checkOutput("hit_nonce", nonce, 5);
    checkOutput("hit_busy", 32'(busy), 0);
    checkOutput("hit_blk_seq", {30'd0, blkQ[0]} * 16 + {30'd0, blkQ[1]} * 4 + {30'd0, blkQ[2]}, 32'h1B);
    tick(1);
    checkOutput("hit_done_pulse", 32'(done), 0);
    checkOutput("hit_found_held", 32'(found), 1);
    checkOutput("hit_block_idle", 32'(block), 0);

    $display("[TB] miss, miss, hit");
    applyStimulus(32'd5);
    checkOutput("s_found_clr", 32'(found), 0);
    checkOutput("s_busy", 32'(busy), 1);
    checkOutput("s_w_load", 32'(w_load), 1);
    checkOutput("s_nonce", nonce, 5);
    tick(1);
    checkOutput("s_round0", 32'(round), 0);
    checkOutput("s_round_en", 32'(round_en), 1);
    tick(1);
    checkOutput("s_round1", 32'(round), 1);
    waitDone(FIRST_COST + MISS_COST - 2, cycles);
    checkOutput("mmh_latency", cycles + 2, FIRST_COST + 2 * MISS_COST);
    checkOutput("mmh_found", 32'(found), 1);
    checkOutput("mmh_nonce", nonce, 7);
    checkOutput("mmh_final_cnt", nonceQ.size(), 3);
    checkOutput("mmh_nonce_seq", nonceQ[0] * 256 + nonceQ[1] * 16 + nonceQ[2], 32'h567);
    checkOutput("mmh_blk4", 32'(blkQ[3]), FOURTH_BLK);

    $display("[TB] nonce ceiling");
    applyStimulus(32'hFFFF_FFFE);
    waitDone(0, cycles);
    checkOutput("top_latency", cycles, FIRST_COST + MISS_COST);
    checkOutput("top_found", 32'(found), 0);
    checkOutput("top_nonce", nonce, 32'hFFFF_FFFF);
    checkOutput("top_busy", 32'(busy), 0);

    $display("[TB] abort in chunk2");
    applyStimulus(32'd9);
    tick(97);
    checkOutput("ab_round", 32'(round), 30);
    checkOutput("ab_chunk_sel", 32'(chunk_sel), 1);
    checkOutput("ab_block", 32'(block), 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checkOutput("ab_busy", 32'(busy), 0);
    checkOutput("ab_done", 32'(done), 1);
    checkOutput("ab_found", 32'(found), 0);
    checkOutput("ab_strobes", {29'd0, w_load, round_en, accum_en}, 0);
    tick(1);
    checkOutput("ab_done_pulse", 32'(done), 0);

    $display("[TB] reset mid-search");
    applyStimulus(32'd12);
    tick(11);
    checkOutput("rs_round", 32'(round), 10);
    doneBefore = doneCount;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rs_nonce", nonce, 0);
    checkOutput("rs_round0", 32'(round), 0);
    checkOutput("rs_flags", {22'd0, block, chunk_sel, w_load, round_en, accum_en, busy, done, found}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    checkOutput("rs_no_done", doneCount - doneBefore, 0);

    $display("[TB] start while busy");
    hash_hit = 1'b1;
    applyStimulus(32'd100);
    tick(5);
    applyStimulus(32'd200);
    checkOutput("sb_nonce", nonce, 100);
    hash_hit = 1'b1;
    waitDone(0, cycles);
    checkOutput("sb_latency", cycles, FIRST_COST - 6);
    checkOutput("sb_nonce_end", nonce, 100);
    checkOutput("sb_found", 32'(found), 1);
    checkOutput("strobe_excl", exclBad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
